// File: rtl/rvfi_retire_tracker_pkg.sv
// Shared core definitions for the RVFI retire tracker: memory access type codes,
// the retire record layout and the byte-mask helper.
package rvfi_retire_tracker_pkg;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_B    = 3'd1,
        MEM_H    = 3'd2,
        MEM_W    = 3'd3,
        MEM_BU   = 3'd4,
        MEM_HU   = 3'd5
    } mem_typ_e;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_rec_t;

    localparam int REC_W = $bits(rvfi_rec_t);

    // Access-size mask aligned to the byte offset; bytes past lane 3 fall off.
    function automatic logic [3:0] mem_byte_mask(input logic [2:0] typ, input logic [1:0] off);
        logic [3:0] base;
        case (mem_typ_e'(typ))
            MEM_B, MEM_BU: base = 4'b0001;
            MEM_H, MEM_HU: base = 4'b0011;
            MEM_W:         base = 4'b1111;
            default:       base = 4'b0000;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/rvfi_mport_fifo.sv
// Multi-write-port, single-read-port FIFO with combinational head. Writes are taken
// in port order; ports that do not fit in the space left (counting this cycle's pop) are dropped.
module rvfi_mport_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NWR   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR*WIDTH-1:0]     wr_data,
    output logic                     wr_drop,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop;
    logic [AW:0]      cap;
    logic [AW:0]      slot;

    always_comb begin
        pop     = (count_q != '0) && rd_ready;
        cap     = (AW+1)'(DEPTH) - count_q + (AW+1)'(pop);
        slot    = '0;
        wr_drop = 1'b0;
        mem_d   = mem_q;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i]) begin
                if (slot < cap) begin
                    mem_d[wr_ptr_q + slot[AW-1:0]] = wr_data[i*WIDTH +: WIDTH];
                    slot = slot + (AW+1)'(1);
                end else begin
                    wr_drop = 1'b1;
                end
            end
        end
        wr_ptr_d = wr_ptr_q + slot[AW-1:0];
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + slot - (AW+1)'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/rvfi_retire_tracker.sv
// Turns per-channel retire strobes into ordered RVFI records, waits MEM_LAT cycles
// for load data, then queues them for a ready/valid consumer.
module rvfi_retire_tracker
    import rvfi_retire_tracker_pkg::*;
#(
    parameter int NRET    = 1,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NRET-1:0]          ret_valid,
    input  logic [32*NRET-1:0]       ret_insn,
    input  logic [32*NRET-1:0]       ret_pc,
    input  logic [32*NRET-1:0]       ret_next_pc,
    input  logic [NRET-1:0]          ret_trap,
    input  logic [5*NRET-1:0]        ret_rd_addr,
    input  logic [32*NRET-1:0]       ret_rd_wdata,
    input  logic [NRET-1:0]          ret_mem,
    input  logic [31:0]              mem_addr,
    input  logic                     mem_we,
    input  logic [2:0]               mem_typ,
    input  logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    output logic                     rvfi_valid,
    input  logic                     rvfi_ready,
    output logic [63:0]              rvfi_order,
    output logic [31:0]              rvfi_insn,
    output logic [31:0]              rvfi_pc_rdata,
    output logic [31:0]              rvfi_pc_wdata,
    output logic                     rvfi_trap,
    output logic [4:0]               rvfi_rd_addr,
    output logic [31:0]              rvfi_rd_wdata,
    output logic [31:0]              rvfi_mem_addr,
    output logic [3:0]               rvfi_mem_rmask,
    output logic [3:0]               rvfi_mem_wmask,
    output logic [31:0]              rvfi_mem_rdata,
    output logic [31:0]              rvfi_mem_wdata,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    logic [63:0]         order_q, order_d;
    logic                overflow_q, overflow_d;
    logic [NRET-1:0]     push_valid;
    logic [NRET*REC_W-1:0] push_data;
    logic                push_drop;
    logic [REC_W-1:0]    head_data;
    rvfi_rec_t           head;

    always_comb begin
        order_d = order_q;
        for (int i = 0; i < NRET; i++) begin
            if (ret_valid[i]) begin
                order_d = order_d + 64'd1;
            end
        end
        overflow_d = overflow_q | push_drop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            order_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            order_q    <= order_d;
            overflow_q <= overflow_d;
        end
    end

    for (genvar gi = 0; gi < NRET; gi++) begin : g_ch
        rvfi_rec_t  ret_rec;
        rvfi_rec_t  lat_rec;
        rvfi_rec_t  push_rec;
        logic       lat_valid;
        logic [63:0] rank;
        logic [3:0] mask;

        // Rank among this cycle's valid channels gives the order offset, so gaps in
        // ret_valid never leave holes in the sequence.
        always_comb begin
            rank = '0;
            for (int j = 0; j < gi; j++) begin
                if (ret_valid[j]) begin
                    rank = rank + 64'd1;
                end
            end
            mask             = mem_byte_mask(mem_typ, mem_addr[1:0]);
            ret_rec          = '0;
            ret_rec.order    = order_q + rank;
            ret_rec.insn     = ret_insn[gi*32 +: 32];
            ret_rec.pc       = ret_pc[gi*32 +: 32];
            ret_rec.next_pc  = ret_next_pc[gi*32 +: 32];
            ret_rec.trap     = ret_trap[gi];
            ret_rec.rd_addr  = ret_rd_addr[gi*5 +: 5];
            ret_rec.rd_wdata = (ret_rd_addr[gi*5 +: 5] == 5'd0) ? 32'h0 : ret_rd_wdata[gi*32 +: 32];
            if (ret_mem[gi]) begin
                ret_rec.mem_addr = mem_addr;
                if (mem_we) begin
                    ret_rec.mem_wmask = mask;
                    ret_rec.mem_wdata = mem_wdata;
                end else begin
                    ret_rec.mem_rmask = mask;
                end
            end
        end

        if (MEM_LAT == 0) begin : g_nolat
            assign lat_rec   = ret_rec;
            assign lat_valid = ret_valid[gi];
        end else begin : g_lat
            rvfi_rec_t          stg_rec_q [MEM_LAT];
            rvfi_rec_t          stg_rec_d [MEM_LAT];
            logic [MEM_LAT-1:0] stg_valid_q, stg_valid_d;

            always_comb begin
                stg_valid_d    = '0;
                stg_valid_d[0] = ret_valid[gi];
                stg_rec_d[0]   = ret_rec;
                for (int s = 1; s < MEM_LAT; s++) begin
                    stg_valid_d[s] = stg_valid_q[s-1];
                    stg_rec_d[s]   = stg_rec_q[s-1];
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    stg_valid_q <= '0;
                    for (int s = 0; s < MEM_LAT; s++) begin
                        stg_rec_q[s] <= '0;
                    end
                end else begin
                    stg_valid_q <= stg_valid_d;
                    stg_rec_q   <= stg_rec_d;
                end
            end

            assign lat_rec   = stg_rec_q[MEM_LAT-1];
            assign lat_valid = stg_valid_q[MEM_LAT-1];
        end

        always_comb begin
            push_rec           = lat_rec;
            push_rec.mem_rdata = (lat_rec.mem_rmask != 4'b0000) ? mem_rdata : 32'h0;
        end

        assign push_valid[gi]                 = lat_valid;
        assign push_data[gi*REC_W +: REC_W]   = push_rec;
    end

    rvfi_mport_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH),
        .NWR   (NRET)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (push_valid),
        .wr_data  (push_data),
        .wr_drop  (push_drop),
        .rd_ready (rvfi_ready),
        .rd_valid (rvfi_valid),
        .rd_data  (head_data),
        .count    (fifo_count)
    );

    assign head           = head_data;
    assign rvfi_order     = head.order;
    assign rvfi_insn      = head.insn;
    assign rvfi_pc_rdata  = head.pc;
    assign rvfi_pc_wdata  = head.next_pc;
    assign rvfi_trap      = head.trap;
    assign rvfi_rd_addr   = head.rd_addr;
    assign rvfi_rd_wdata  = head.rd_wdata;
    assign rvfi_mem_addr  = head.mem_addr;
    assign rvfi_mem_rmask = head.mem_rmask;
    assign rvfi_mem_wmask = head.mem_wmask;
    assign rvfi_mem_rdata = head.mem_rdata;
    assign rvfi_mem_wdata = head.mem_wdata;
    assign overflow       = overflow_q;

endmodule

// File: doc/rvfi_retire_tracker.md
RVFI_RETIRE_TRACKER -- requirements
Module: rvfi_retire_tracker

Interface
REQ-001 SHALL have parameter NRET, default 1: retire channels per cycle, legal values 1 and 2; channel 0 is older than channel 1.
REQ-002 SHALL have parameter DEPTH, default 4: output FIFO entries, a power of 2 and at least 2.
REQ-003 SHALL have parameter MEM_LAT, default 1: cycles from retire to valid mem_rdata, legal values 0 to 2.
REQ-004 SHALL have ports, clock and reset first:
  clock  in  1  sole clock; all logic is on the rising edge
  reset  in  1  asynchronous, active-high reset
  ret_valid  in  NRET  retire strobe per channel
  ret_insn  in  32*NRET  instruction word per channel
  ret_pc  in  32*NRET  PC of the retired instruction per channel
  ret_next_pc  in  32*NRET  next PC per channel
  ret_trap  in  NRET  exception flag per channel
  ret_rd_addr  in  5*NRET  destination register per channel
  ret_rd_wdata  in  32*NRET  writeback data per channel
  ret_mem  in  NRET  channel carries the cycle's memory access; at most one bit set
  mem_addr  in  32  data address, sampled in the retire cycle
  mem_we  in  1  1 = store, sampled in the retire cycle
  mem_typ  in  3  1=B, 2=H, 3=W, 4=BU, 5=HU; sampled in the retire cycle
  mem_wdata  in  32  store data, sampled in the retire cycle
  mem_rdata  in  32  load data, valid MEM_LAT cycles after the retire cycle
  rvfi_valid  out  1  output record valid
  rvfi_ready  in  1  consumer accepts the record
  rvfi_order  out  64  retire sequence number
  rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata  out  32 each  insn, pc, next pc
  rvfi_trap  out  1  exception flag
  rvfi_rd_addr  out  5  destination register
  rvfi_rd_wdata  out  32  writeback data
  rvfi_mem_addr  out  32  data address
  rvfi_mem_rmask  out  4  load byte mask
  rvfi_mem_wmask  out  4  store byte mask
  rvfi_mem_rdata  out  32  load data
  rvfi_mem_wdata  out  32  store data
  fifo_count  out  log2(DEPTH)+1  occupied FIFO entries
  overflow  out  1  sticky flag: a record was dropped

Function
REQ-005 SHALL build one record per asserted ret_valid bit, with a record order of base+k, where k is the channel's rank among the valid channels in that cycle.
REQ-006 SHALL advance the 64-bit order base by popcount(ret_valid) every cycle and wrap modulo 2^64.
REQ-007 SHALL force rd_wdata to 0 in the record whenever rd_addr is 0.
REQ-008 SHALL derive the byte mask from mem_typ: B/BU give 0001, H/HU give 0011, W gives 1111, and any other code gives 0000.
REQ-009 SHALL shift the byte mask left by mem_addr[1:0] and truncate it to 4 bits.
REQ-010 SHALL place the mask in wmask when mem_we is 1 and in rmask when mem_we is 0; a record whose ret_mem bit is clear SHALL carry masks 0, mem_addr 0 and wdata 0.
REQ-011 SHALL delay every record through a MEM_LAT-stage pipeline, then merge mem_rdata into the record if its rmask is nonzero (rdata 0 otherwise) and push it to the FIFO.
REQ-012 SHALL push up to NRET records per cycle into the FIFO, oldest first.
REQ-013 SHALL pop one record per cycle when rvfi_valid and rvfi_ready are both 1.
REQ-014 SHALL drive rvfi_valid = (fifo_count != 0) and present the head record combinationally from FIFO storage.
REQ-015 SHALL evaluate capacity as free entries plus the pop in that cycle (push-on-full with a simultaneous pop succeeds).
REQ-016 SHALL, when capacity is less than the number of pushes, accept the oldest records that fit, drop the rest, and set overflow.
REQ-017 SHALL keep consumed order numbers for dropped records, so the consumer sees a gap.
REQ-018 SHALL hold the head record and rvfi_valid stable while rvfi_ready is 0.
REQ-019 SHALL, with MEM_LAT=0, merge mem_rdata in the retire cycle and push in that same cycle.

Reset
REQ-020 SHALL, while reset is 1, clear asynchronously: FIFO pointers, fifo_count, overflow, order base and all pipeline-stage valid bits.
REQ-021 SHALL, during reset, drive rvfi_valid 0, fifo_count 0 and overflow 0; data outputs SHALL read 0 from cleared storage.
REQ-022 SHALL discard in-flight pipeline records on reset mid-operation, and the first record after reset SHALL have order 0.

Structure
REQ-023 SHALL take the mem_typ codes and the record struct (order, insn, pc, next_pc, trap, rd, mem fields) from the shared core package.
REQ-024 SHALL implement the FIFO as one sub-module, rvfi_mport_fifo, with NRET write ports, one read port and parameters WIDTH and DEPTH.

Verification
REQ-025 SHALL cover single retire (NRET=1, MEM_LAT=1): insn 0x00A00093, rd=1, wdata 0xA, ready=1 -> one record, order 0, masks 0, valid two cycles after retire.
REQ-026 SHALL cover load: lh at addr 0x1002, mem_rdata 0xBEEF0000 one cycle later -> rmask 1100, wmask 0000, rdata 0xBEEF0000.
REQ-027 SHALL cover dual retire (NRET=2): valid=11 then valid=10 -> orders 0,1,2 in that sequence; channel 1 is popped after channel 0.
REQ-028 SHALL cover full FIFO (DEPTH=4, ready=0): 6 single retires -> fifo_count 4, overflow 1; after ready=1, orders 0,1,2,3 are output.
REQ-029 SHALL cover simultaneous push and pop at full with ready=1 -> count stays 4 and overflow stays 0.
REQ-030 SHALL cover reset with 3 entries queued -> rvfi_valid 0 at once; the next retire outputs order 0 with rd_addr 0 and rd_wdata 0.
